// File: rtl/rice_cost_accumulator_pkg.sv
// Shared constants and the zigzag fold for the Rice-parameter cost path.
// The downstream minimum comparator sizes its inputs from the same ACC_W/NUM_K.
package rice_cost_accumulator_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_K  = 12;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Interleave signs so small magnitudes map to small codes: 0,-1,1,-2,2 -> 0,1,2,3,4.
  function automatic logic [DATA_W-1:0] zigzag(input logic signed [DATA_W-1:0] r);
    return {r[DATA_W-2:0], 1'b0} ^ {DATA_W{r[DATA_W-1]}};
  endfunction

endpackage

// File: rtl/rice_cost_lane.sv
// One Rice parameter lane: saturating accumulation of (u>>K)+1+K.
// The combinational sum is exported so the top can capture a completed partition.
module rice_cost_lane
  import rice_cost_accumulator_pkg::*;
#(
  parameter int K = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              accept,
  input  logic              first,
  input  logic [DATA_W-1:0] u,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] acc_p2;
  logic [ACC_W-1:0] addend;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  assign addend = ACC_W'(u >> K) + ACC_W'(K + 1);
  assign sum    = sat_add(first ? '0 : acc_p2, addend);

  // stage 2: accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (en && accept) begin
      acc_p2 <= sum;
    end
  end

endmodule

// File: rtl/rice_cost_accumulator.sv
// Zigzag-folds residuals and accumulates Rice coding cost for k = 0..NUM_K-1
// over one partition, presenting all costs with a one-cycle oValid pulse.
module rice_cost_accumulator
  import rice_cost_accumulator_pkg::*;
(
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEnable,
  input  logic                     iValid,
  input  logic signed [DATA_W-1:0] iResidual,
  input  logic                     iLast,
  output logic [ACC_W-1:0]         oCost0,
  output logic [ACC_W-1:0]         oCost1,
  output logic [ACC_W-1:0]         oCost2,
  output logic [ACC_W-1:0]         oCost3,
  output logic [ACC_W-1:0]         oCost4,
  output logic [ACC_W-1:0]         oCost5,
  output logic [ACC_W-1:0]         oCost6,
  output logic [ACC_W-1:0]         oCost7,
  output logic [ACC_W-1:0]         oCost8,
  output logic [ACC_W-1:0]         oCost9,
  output logic [ACC_W-1:0]         oCost10,
  output logic [ACC_W-1:0]         oCost11,
  output logic [CNT_W-1:0]         oSamples,
  output logic                     oValid
);

  logic [DATA_W-1:0] u_p1;
  logic              vld_p1;
  logic              last_p1;

  logic              first_p2;
  logic              vld_p2;
  logic [CNT_W-1:0]  cnt_p2;
  logic [CNT_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  samples_p2;
  logic [ACC_W-1:0]  sum_p2  [NUM_K];
  logic [ACC_W-1:0]  cost_p2 [NUM_K];

  // stage 1: zigzag fold
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (iEnable) begin
      vld_p1  <= iValid;
      last_p1 <= iValid & iLast;
    end
  end

  always_ff @(posedge iClock) begin
    if (iEnable) begin
      u_p1 <= zigzag(iResidual);
    end
  end

  // stage 2: per-k accumulation, sample count and completion capture
  for (genvar k = 0; k < NUM_K; k++) begin : g_lane
    rice_cost_lane #(.K(k)) u_lane (
      .clk    (iClock),
      .rst_n  (iReset),
      .en     (iEnable),
      .accept (vld_p1),
      .first  (first_p2),
      .u      (u_p1),
      .sum    (sum_p2[k])
    );
  end

  assign cnt_sum = first_p2 ? CNT_W'(1) : ((cnt_p2 == CNT_MAX) ? CNT_MAX : cnt_p2 + 1'b1);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      first_p2   <= 1'b1;
      vld_p2     <= 1'b0;
      cnt_p2     <= '0;
      samples_p2 <= '0;
      for (int k = 0; k < NUM_K; k++) cost_p2[k] <= '0;
    end else if (iEnable) begin
      vld_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        first_p2 <= last_p1;
        cnt_p2   <= cnt_sum;
      end
      if (vld_p1 && last_p1) begin
        samples_p2 <= cnt_sum;
        for (int k = 0; k < NUM_K; k++) cost_p2[k] <= sum_p2[k];
      end
    end
  end

  // A pulse held over a stall is masked until the pipeline advances, so it shows once.
  assign oValid   = vld_p2 & iEnable;
  assign oSamples = samples_p2;
  assign oCost0   = cost_p2[0];
  assign oCost1   = cost_p2[1];
  assign oCost2   = cost_p2[2];
  assign oCost3   = cost_p2[3];
  assign oCost4   = cost_p2[4];
  assign oCost5   = cost_p2[5];
  assign oCost6   = cost_p2[6];
  assign oCost7   = cost_p2[7];
  assign oCost8   = cost_p2[8];
  assign oCost9   = cost_p2[9];
  assign oCost10  = cost_p2[10];
  assign oCost11  = cost_p2[11];

endmodule

// File: tb/tb_rice_cost_accumulator.sv
// Directed bench for rice_cost_accumulator with hand-computed expected costs.
module tb_rice_cost_accumulator;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iValid;
  logic signed [15:0] iResidual;
  logic               iLast;
  logic [31:0]        cost [12];
  logic [15:0]        oSamples;
  logic               oValid;

  int n_cmp = 0;
  int n_err = 0;

  rice_cost_accumulator dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iValid    (iValid),
    .iResidual (iResidual),
    .iLast     (iLast),
    .oCost0    (cost[0]),
    .oCost1    (cost[1]),
    .oCost2    (cost[2]),
    .oCost3    (cost[3]),
    .oCost4    (cost[4]),
    .oCost5    (cost[5]),
    .oCost6    (cost[6]),
    .oCost7    (cost[7]),
    .oCost8    (cost[8]),
    .oCost9    (cost[9]),
    .oCost10   (cost[10]),
    .oCost11   (cost[11]),
    .oSamples  (oSamples),
    .oValid    (oValid)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int r, input logic l);
    iValid    = v;
    iResidual = 16'(r);
    iLast     = l;
    @(posedge iClock);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    for (int k = 0; k < 12; k++) chk($sformatf("%s_cost%0d", tag, k), cost[k], 32'd0);
    chk({tag, "_samples"}, 32'(oSamples), 32'd0);
    chk({tag, "_valid"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    iReset = 1'b0; iEnable = 1'b1; iValid = 1'b0; iResidual = '0; iLast = 1'b0;
    repeat (3) @(posedge iClock);
    #1;
    chk_cleared("rst_init");
    iReset = 1'b1;
    drive(0, 0, 0);

    // partition {0,-1,1,2} with bubbles and a stray iLast that must be ignored
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(1, -1, 0);
    drive(0, 0, 0);
    drive(1, 1, 0);
    drive(1, 2, 1);
    chk("p4_early_valid", 32'(oValid), 32'd0);
    drive(0, 0, 0);
    chk("p4_valid", 32'(oValid), 32'd1);
    chk("p4_cost0", cost[0], 32'd11);
    chk("p4_cost1", cost[1], 32'd11);
    chk("p4_cost2", cost[2], 32'd13);
    chk("p4_cost3", cost[3], 32'd16);
    chk("p4_cost4", cost[4], 32'd20);
    chk("p4_cost11", cost[11], 32'd48);
    chk("p4_samples", 32'(oSamples), 32'd4);
    drive(0, 0, 0);
    chk("p4_valid_drop", 32'(oValid), 32'd0);
    chk("p4_cost0_hold", cost[0], 32'd11);

    // back-to-back: {3} then {-2,-2}
    drive(1, 3, 1);
    chk("b2b_v0", 32'(oValid), 32'd0);
    drive(1, -2, 0);
    chk("b2b_v1", 32'(oValid), 32'd1);
    chk("b2b_a_cost0", cost[0], 32'd7);
    chk("b2b_a_samples", 32'(oSamples), 32'd1);
    drive(1, -2, 1);
    chk("b2b_v2", 32'(oValid), 32'd0);
    drive(0, 0, 0);
    chk("b2b_v3", 32'(oValid), 32'd1);
    chk("b2b_b_cost0", cost[0], 32'd8);
    chk("b2b_b_cost1", cost[1], 32'd6);
    chk("b2b_b_samples", 32'(oSamples), 32'd2);
    drive(0, 0, 0);
    chk("b2b_v4", 32'(oValid), 32'd0);

    // stall with the completion in flight: {5} -> u=10, cost0=11, cost1=7
    drive(1, 5, 1);
    iValid  = 1'b0;
    iLast   = 1'b0;
    iEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge iClock);
      #1;
      chk($sformatf("stall_v%0d", i), 32'(oValid), 32'd0);
    end
    chk("stall_cost0_old", cost[0], 32'd8);
    iEnable = 1'b1;
    drive(0, 0, 0);
    chk("stall_valid", 32'(oValid), 32'd1);
    chk("stall_cost0", cost[0], 32'd11);
    chk("stall_cost1", cost[1], 32'd7);
    drive(0, 0, 0);
    chk("stall_single", 32'(oValid), 32'd0);

    // asynchronous reset mid-partition, then {1}
    drive(1, 100, 0);
    drive(1, 200, 0);
    drive(1, 300, 0);
    #2;
    iReset = 1'b0;
    #1;
    chk_cleared("rst_mid");
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    drive(1, 1, 1);
    chk("post_rst_v0", 32'(oValid), 32'd0);
    drive(0, 0, 0);
    chk("post_rst_valid", 32'(oValid), 32'd1);
    chk("post_rst_cost0", cost[0], 32'd3);
    chk("post_rst_cost1", cost[1], 32'd3);
    chk("post_rst_samples", 32'(oSamples), 32'd1);

    // saturation: 70000 samples of -32768 (u=65535)
    for (int i = 0; i < 69999; i++) drive(1, -32768, 0);
    drive(1, -32768, 1);
    drive(0, 0, 0);
    chk("sat_valid", 32'(oValid), 32'd1);
    chk("sat_cost0", cost[0], 32'hFFFF_FFFF);
    chk("sat_cost1", cost[1], 32'd2293830000);
    chk("sat_cost11", cost[11], 32'd3010000);
    chk("sat_samples", 32'(oSamples), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
